// File: rtl/dmem_arbiter.sv
// Shares one data memory between the core datapath and a host/debug port, with a starvation limit for the host.
// Optional statistics counters are built when DMEM_ARB_STATS_EN is defined.
module dmem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        core_rd,
  input  logic        core_wr,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  output logic [31:0] core_rdata,
  output logic        core_stall,
  input  logic        host_req,
  input  logic        host_we,
  input  logic [31:0] host_addr,
  input  logic [31:0] host_wdata,
  output logic [31:0] host_rdata,
  output logic        host_ack,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
`ifdef DMEM_ARB_STATS_EN
  ,
  output logic [15:0] host_grant_cnt,
  output logic [15:0] stall_cycle_cnt
`endif
);

  typedef enum logic [1:0] {IDLE, HOST, ACK} state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t      state, nextState;
  logic [3:0]  starveCnt;
  logic        coreAccess;
  logic        grant;

  assign coreAccess = core_rd | core_wr;
  assign grant      = (state == IDLE) && host_req && (!coreAccess || starveCnt == LIMIT);
  assign core_rdata = mem_rdata;

  always_comb begin
    nextState = state;
    unique case (state)
      IDLE:    if (grant) nextState = HOST;
      HOST:    nextState = ACK;
      ACK:     nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Reset gates the strobes combinationally so an in-flight host write is dropped in the reset cycle.
  always_comb begin
    mem_read   = core_rd;
    mem_write  = core_wr;
    mem_addr   = core_addr;
    mem_wdata  = core_wdata;
    core_stall = 1'b0;
    host_ack   = 1'b0;
    if (reset) begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end else begin
      unique case (state)
        HOST: begin
          mem_read   = !host_we;
          mem_write  = host_we;
          mem_addr   = host_addr;
          mem_wdata  = host_wdata;
          core_stall = coreAccess;
        end
        ACK:     host_ack = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      starveCnt  <= '0;
      host_rdata <= '0;
    end else begin
      state <= nextState;
      if (grant)
        starveCnt <= '0;
      else if (state == IDLE && host_req && coreAccess && starveCnt != LIMIT)
        starveCnt <= starveCnt + 4'd1;
      if (state == HOST && !host_we)
        host_rdata <= mem_rdata;
    end
  end

`ifdef DMEM_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      host_grant_cnt  <= '0;
      stall_cycle_cnt <= '0;
    end else begin
      if (grant && host_grant_cnt != '1)
        host_grant_cnt <= host_grant_cnt + 16'd1;
      if (core_stall && stall_cycle_cnt != '1)
        stall_cycle_cnt <= stall_cycle_cnt + 16'd1;
    end
  end
`endif

endmodule
